// File: rtl/pixel_spike_encoder.sv
// Rate-codes a captured frame of pixel intensities into per-timestep spike vectors
// using one phase accumulator per pixel; the accumulator carry is the spike.
module pixel_spike_encoder #(
    parameter int unsigned N_PIX   = 5,
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned N_STEPS = 16,
    localparam int unsigned STEP_W = $clog2(N_STEPS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pulse,
    input  logic                     start,
    input  logic                     abort,
    input  logic [N_PIX*PIX_W-1:0]   pixels_in,
    output logic [N_PIX-1:0]         pixel_spk,
    output logic                     spk_valid,
    output logic                     busy,
    output logic                     done,
    output logic [STEP_W-1:0]        step_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [N_PIX-1:0][PIX_W-1:0] pix_q, pix_d;
    logic [N_PIX-1:0][PIX_W-1:0] acc_q, acc_d;
    logic [N_PIX-1:0][PIX_W:0]   sum_c;
    logic [N_PIX-1:0]            spk_q, spk_d;
    logic                        valid_q, valid_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [STEP_W-1:0]           step_q, step_d;
    logic                        last_step_c;

    assign last_step_c = (step_q == STEP_W'(N_STEPS));

    // Per-pixel accumulate, one bit wider so the top bit is the carry/spike.
    always_comb begin
        for (int i = 0; i < int'(N_PIX); i++) begin
            sum_c[i] = (PIX_W + 1)'(acc_q[i]) + (PIX_W + 1)'(pix_q[i]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks the terminating pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pulse && last_step_c) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        pix_d   = pix_q;
        acc_d   = acc_q;
        step_d  = step_q;
        spk_d   = spk_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = (state_d == RUN);
        case (state_q)
            IDLE: begin
                spk_d = '0;
                if (start) begin
                    pix_d  = pixels_in;
                    acc_d  = '0;
                    step_d = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    spk_d  = '0;
                    acc_d  = '0;
                    step_d = '0;
                end else if (pulse) begin
                    if (!last_step_c) begin
                        for (int i = 0; i < int'(N_PIX); i++) begin
                            acc_d[i] = sum_c[i][PIX_W-1:0];
                            spk_d[i] = sum_c[i][PIX_W];
                        end
                        step_d  = step_q + STEP_W'(1);
                        valid_d = 1'b1;
                    end else begin
                        spk_d  = '0;
                        done_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_q   <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            spk_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pix_q   <= pix_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            spk_q   <= spk_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pixel_spk = spk_q;
    assign spk_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign step_cnt  = step_q;

endmodule

// File: tb/tb_pixel_spike_encoder.sv
// Scoreboard bench for pixel_spike_encoder: a floor-based rate model predicts each
// emitted vector; a negedge monitor pops and compares whenever the DUT presents output.
module tb_pixel_spike_encoder;

    localparam int unsigned N_PIX   = 5;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned N_STEPS = 16;
    localparam int unsigned STEP_W  = $clog2(N_STEPS + 1);

    logic                   clk;
    logic                   reset;
    logic                   pulse;
    logic                   start;
    logic                   abort;
    logic [N_PIX*PIX_W-1:0] pixels_in;
    logic [N_PIX-1:0]       pixel_spk;
    logic                   spk_valid;
    logic                   busy;
    logic                   done;
    logic [STEP_W-1:0]      step_cnt;

    pixel_spike_encoder #(
        .N_PIX  (N_PIX),
        .PIX_W  (PIX_W),
        .N_STEPS(N_STEPS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse    (pulse),
        .start    (start),
        .abort    (abort),
        .pixels_in(pixels_in),
        .pixel_spk(pixel_spk),
        .spk_valid(spk_valid),
        .busy     (busy),
        .done     (done),
        .step_cnt (step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N_PIX-1:0] spk;
        int               step;
        bit               done;
        bit               busy;
        int               cnt[N_PIX];
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: frame intensities, steps emitted, running flag.
    int               m_pix[N_PIX];
    int               m_step = 0;
    bit               m_busy = 1'b0;
    logic [N_PIX-1:0] m_last_spk = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [N_PIX*PIX_W-1:0] pack5(input int p4, input int p3, input int p2,
                                                      input int p1, input int p0);
        return {PIX_W'(p4), PIX_W'(p3), PIX_W'(p2), PIX_W'(p1), PIX_W'(p0)};
    endfunction

    // One stimulus cycle driven at negedge; the model predicts the resulting output.
    task automatic cycle(input bit p, input bit s, input bit a, input logic [N_PIX*PIX_W-1:0] pv);
        exp_t e;
        pulse = p; start = s; abort = a; pixels_in = pv;
        if (!m_busy) begin
            if (s) begin
                m_busy = 1'b1;
                m_step = 0;
                m_last_spk = '0;
                for (int i = 0; i < int'(N_PIX); i++) m_pix[i] = int'(pv[i*PIX_W +: PIX_W]);
            end
        end else if (a) begin
            m_busy = 1'b0;
            m_step = 0;
            m_last_spk = '0;
        end else if (p) begin
            if (m_step < int'(N_STEPS)) begin
                m_step++;
                for (int i = 0; i < int'(N_PIX); i++) begin
                    e.spk[i] = (((m_step * m_pix[i]) >> PIX_W) - (((m_step - 1) * m_pix[i]) >> PIX_W)) != 0;
                    e.cnt[i] = 0;
                end
                e.done = 1'b0;
                e.busy = 1'b1;
            end else begin
                e.spk  = '0;
                e.done = 1'b1;
                e.busy = 1'b0;
                for (int i = 0; i < int'(N_PIX); i++) e.cnt[i] = (int'(N_STEPS) * m_pix[i]) >> PIX_W;
                m_busy = 1'b0;
            end
            e.step = m_step;
            q.push_back(e);
            m_last_spk = e.spk;
        end
        @(negedge clk);
        pulse = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, pixels_in);
    endtask

    // Runs pulses with random gaps until the model says the frame has terminated.
    task automatic finish_frame(input int max_gap, input bit scramble);
        int guard;
        guard = 0;
        while (m_busy && guard < 200) begin
            for (int k = 0; k < int'($urandom_range(max_gap, 0)); k++)
                cycle(1'b0, scramble && ($urandom_range(3, 0) == 0), 1'b0,
                      scramble ? N_PIX*PIX_W'($urandom) : pixels_in);
            cycle(1'b1, 1'b0, 1'b0, pixels_in);
            guard++;
        end
        chk("frame_terminates", 64'(m_busy), 64'(0));
        idle(1);
    endtask

    // Monitor: pops one expectation whenever the DUT presents a vector or done.
    exp_t mon_e;
    int   dcnt[N_PIX];
    always @(negedge clk) begin
        if (reset) begin
            if (spk_valid || done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got valid=%0d done=%0d expected none", spk_valid, done);
                end else begin
                    mon_e = q.pop_front();
                    chk("pixel_spk", 64'(pixel_spk), 64'(mon_e.spk));
                    chk("step_cnt", 64'(step_cnt), 64'(mon_e.step));
                    chk("done", 64'(done), 64'(mon_e.done));
                    chk("busy", 64'(busy), 64'(mon_e.busy));
                    chk("spk_valid", 64'(spk_valid), 64'(!mon_e.done));
                    if (spk_valid) begin
                        for (int i = 0; i < int'(N_PIX); i++) dcnt[i] += int'(pixel_spk[i]);
                    end
                    if (done) begin
                        for (int i = 0; i < int'(N_PIX); i++) chk($sformatf("spike_count%0d", i), 64'(dcnt[i]), 64'(mon_e.cnt[i]));
                    end
                end
            end else if (!busy) begin
                for (int i = 0; i < int'(N_PIX); i++) dcnt[i] = 0;
            end
        end
    end

    initial begin
        logic [N_PIX*PIX_W-1:0] pv;
        reset = 1'b0; pulse = 1'b0; start = 1'b0; abort = 1'b0; pixels_in = '0;
        for (int i = 0; i < int'(N_PIX); i++) dcnt[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_spk", 64'(pixel_spk), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_step", 64'(step_cnt), 64'(0));
        chk("rst_valid_done", 64'({spk_valid, done}), 64'(0));
        reset = 1'b1;
        idle(2);

        // Encoding frame with pulses spaced 3 cycles.
        pv = pack5(255, 128, 64, 16, 0);
        cycle(1'b0, 1'b1, 1'b0, pv);
        for (int k = 0; k < int'(N_STEPS) + 1; k++) begin
            cycle(1'b1, 1'b0, 1'b0, pv);
            idle(2);
        end
        chk("enc_idle_busy", 64'(busy), 64'(0));

        // Start and pulse in the same cycle: that pulse is not a step.
        cycle(1'b1, 1'b1, 1'b0, pack5(200, 33, 7, 1, 99));
        for (int k = 0; k < int'(N_STEPS); k++) cycle(1'b1, 1'b0, 1'b0, pixels_in);
        chk("coll_step", 64'(step_cnt), 64'(N_STEPS));
        chk("coll_busy", 64'(busy), 64'(1));
        chk("coll_done", 64'(done), 64'(0));
        cycle(1'b1, 1'b0, 1'b0, pixels_in);
        idle(1);

        // Start and pixel change during RUN are ignored.
        cycle(1'b0, 1'b1, 1'b0, pack5(17, 250, 3, 128, 90));
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, pixels_in);
        cycle(1'b0, 1'b1, 1'b0, '1);
        finish_frame(1, 1'b0);

        // Abort together with the 5th pulse.
        cycle(1'b0, 1'b1, 1'b0, pack5(255, 128, 64, 16, 0));
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, pixels_in);
        cycle(1'b1, 1'b0, 1'b1, pixels_in);
        chk("abort_spk", 64'(pixel_spk), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_step", 64'(step_cnt), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        cycle(1'b0, 1'b1, 1'b0, pack5(255, 128, 64, 16, 0));
        finish_frame(0, 1'b0);

        // Hold without pulse for 50 cycles mid-frame.
        cycle(1'b0, 1'b1, 1'b0, pack5(3, 255, 129, 77, 200));
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b0, pixels_in);
        idle(1);
        for (int k = 0; k < 50; k++) begin
            chk("hold_spk", 64'(pixel_spk), 64'(m_last_spk));
            chk("hold_step", 64'(step_cnt), 64'(m_step));
            chk("hold_valid", 64'(spk_valid), 64'(0));
            idle(1);
        end
        finish_frame(2, 1'b0);

        // Asynchronous reset mid-cycle at step 7.
        cycle(1'b0, 1'b1, 1'b0, pack5(255, 255, 128, 64, 32));
        for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 1'b0, pixels_in);
        idle(1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_spk", 64'(pixel_spk), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_step", 64'(step_cnt), 64'(0));
        chk("arst_valid_done", 64'({spk_valid, done}), 64'(0));
        chk("arst_queue", 64'(q.size()), 64'(0));
        q.delete();
        m_busy = 1'b0; m_step = 0; m_last_spk = '0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b0, '1);
        chk("post_rst_spk", 64'(pixel_spk), 64'(0));
        chk("post_rst_busy", 64'(busy), 64'(0));

        // Randomized frames with stray starts and pixel changes during RUN.
        for (int f = 0; f < 8; f++) begin
            pv = N_PIX*PIX_W'({$urandom, $urandom});
            if (f == 0) pv = pack5(255, 0, 1, 254, 128);
            cycle($urandom_range(1, 0) == 1, 1'b1, 1'b0, pv);
            finish_frame(3, 1'b1);
        end

        idle(3);
        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_spike_encoder.md
# pixel_spike_encoder

Rate-codes a frame of pixel intensities into per-timestep spike vectors that drive the pixel-spike input of the first spiking layer. A host loads N_PIX intensities with a start strobe. On each `pulse` timestep strobe, shared with the layers, the block emits one spike bit per pixel for N_STEPS timesteps, then signals done. Encoding is a deterministic phase accumulator, so spike counts are exactly predictable for verification.

## Interface
- N_PIX, 5, number of pixels and width of the spike vector
- PIX_W, 8, intensity width and accumulator width
- N_STEPS, 16, timesteps per frame (1..2^16-1)
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- pulse  input  1  timestep strobe; one-cycle high, same strobe the layers use
- start  input  1  one-cycle load request; honoured only in IDLE
- abort  input  1  synchronous cancel; honoured only in RUN
- pixels_in  input  N_PIX*PIX_W  intensities; pixel i is bits [PIX_W*(i+1)-1 : PIX_W*i]
- pixel_spk  output  N_PIX  registered spike vector; feeds the layer pixel-spike input
- spk_valid  output  1  one-cycle high in the cycle after each emitting pulse
- busy  output  1  high in RUN
- done  output  1  one-cycle high when the frame completes
- step_cnt  output  clog2(N_STEPS+1)  number of timesteps emitted in the current frame

## Operation
- States: IDLE and RUN. Reset forces IDLE. Under reset, all outputs, accumulators, captured pixels and step_cnt are 0.
- IDLE with start=1:
  - capture pixels_in into internal registers
  - clear all accumulators and step_cnt
  - go to RUN, with busy=1 from the next cycle
  - a pulse in the same cycle as start is ignored and does not count as a step
- IDLE with start=0: hold; pixel_spk=0.
- RUN, pulse=1 and step_cnt<N_STEPS:
  - for each pixel, {carry, acc_i} = acc_i + pix_i, computed PIX_W+1 bits wide
  - acc_i takes the low PIX_W bits; pixel_spk[i] takes the carry
  - step_cnt increments; spk_valid=1 in the next cycle
- RUN, pulse=1 and step_cnt==N_STEPS (the terminating pulse):
  - pixel_spk goes to 0 and done=1 for one cycle
  - busy goes to 0 and the block returns to IDLE
  - step_cnt holds N_STEPS until the next start
  - total pulses per frame in RUN is N_STEPS+1
- RUN without pulse: every register holds; pixel_spk stays valid for the whole timestep.
- Spike count per pixel over a frame is floor(N_STEPS*pix/2^PIX_W). The first spike for pixel value p occurs at step ceil(2^PIX_W/p). Pixel 0 never spikes.
- start in RUN is ignored; a change on pixels_in during RUN has no effect.
- abort in RUN:
  - next cycle is IDLE with pixel_spk=0, busy=0, step_cnt=0
  - no done
  - abort wins over a simultaneous pulse
- Accumulator wrap is the intended carry mechanism; no saturation.

## Timing
- Latency from pulse to pixel_spk update: 1 cycle, registered.
- Downstream layers sample pixel_spk on the following pulse, giving a one-timestep pipeline offset by design.
- spk_valid, done and busy are registered and change in the same cycle as pixel_spk.
- Minimum spacing between pulses is 1 cycle (back-to-back pulses are legal).
- reset low asynchronously clears every output in the same cycle, independent of clk. Release is synchronous to the next clk edge.
- Frame throughput: a start is accepted no earlier than the cycle in which done is high.

## Test plan
- Encoding:
  - stimulus: N_STEPS=16, pixels {255,128,64,16,0} (pixel4..pixel0), start, then 17 pulses spaced 3 cycles
  - required counts: 15, 8, 4, 1, 0
  - pixel 3 (128) spikes on steps 2,4,…,16
  - pixel 1 (16) spikes only on step 16
  - done is high for exactly 1 cycle after the 17th pulse
- Start/pulse collision: start and pulse in the same cycle, then 16 pulses -> step_cnt=16, busy=1, done=0; done asserts after the 17th pulse.
- Start and pixel change in RUN: after step 3, assert start with pixels all 0xFF -> ignored; counts match the original frame.
- Abort: abort at step 5, simultaneous with a pulse -> next cycle pixel_spk=0, busy=0, step_cnt=0, no done. A new start runs a fresh frame from acc=0.
- Reset mid-run: reset low at step 7, mid-cycle -> all outputs 0 immediately. After release, state is IDLE and pulses produce no spikes.
- Hold without pulse: 50 idle cycles in RUN -> pixel_spk, step_cnt and spk_valid=0 all stable.
